// File: rtl/tnn_pkg.sv
// Shared types and constants for the ternary (TNN) datapath.
// Used by threshold_compress (encode) and ternary_decompress (decode).
//   trit_t         : one 2-bit trit, 00 = 0, 01 = +1, 11 = -1 (10 unused)
//   TRITS_PER_BYTE : trits packed in one base-3 byte (3^5 = 243 <= 256)
//   MAX_CODE       : largest legal packed byte value
package tnn_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_ZERO = 2'b00;
  localparam trit_t TRIT_POS  = 2'b01;
  localparam trit_t TRIT_NEG  = 2'b11;

  localparam int TRITS_PER_BYTE = 5;
  localparam int MAX_CODE       = 242;

  // Base-3 digit d in {0,1,2} carries trit value d - 1.
  function automatic trit_t digit_to_trit(input logic [1:0] digit);
    case (digit)
      2'd0:    return TRIT_NEG;
      2'd1:    return TRIT_ZERO;
      default: return TRIT_POS;
    endcase
  endfunction

endpackage

// File: rtl/ternary_byte_decode.sv
// Combinational decode of one base-3 packed byte into five 2-bit trits.
// Ports:
//   code    in  8   packed byte, value = sum d_i * 3^i, d_i = t_i + 1
//   trits   out 10  trit i on trits[2i+1:2i]; all zero for invalid codes
//   invalid out 1   code is above MAX_CODE (243..255)
module ternary_byte_decode
  import tnn_pkg::*;
(
  input  logic [7:0]                  code,
  output logic [2*TRITS_PER_BYTE-1:0] trits,
  output logic                        invalid
);

  logic [7:0] rem;
  logic [1:0] digit;

  // Divide-by-3 chain: each stage peels off the least significant digit.
  // NOTE: combinational logic uses blocking assignments and gives every
  // variable a default at the top, so no path can leave a latch behind.
  always_comb begin
    rem     = code;
    digit   = '0;
    trits   = '0;
    invalid = (code > 8'(MAX_CODE));
    for (int i = 0; i < TRITS_PER_BYTE; i++) begin
      digit          = 2'(rem % 8'd3);
      trits[2*i +: 2] = digit_to_trit(digit);
      rem            = rem / 8'd3;
    end
    if (invalid) trits = '0;
  end

endmodule

// File: rtl/ternary_decompress.sv
// Ternary decompressor: accepts words of packed base-3 bytes and emits one
// decoded byte (five trits) per cycle over a valid/ready handshake.
// Ports:
//   clk_i        in  1        clock
//   rst_ni       in  1        synchronous active-low reset
//   clear_i      in  1        synchronous flush, also clears error_o
//   data_i       in  8*BPW    packed bytes, byte 0 in bits [7:0] goes first
//   nbytes_m1_i  in  log2 BPW valid bytes in data_i minus one
//   valid_i      in  1        input word valid
//   ready_o      out 1        word can be accepted this cycle
//   trits_o      out 10       decoded trits of the current byte
//   valid_o      out 1        trits_o valid
//   ready_i      in  1        consumer takes trits_o
//   last_o       out 1        trits_o is the last valid byte of the word
//   error_o      out 1        sticky: an invalid code (>= 243) was decoded
// BYTES_PER_WORD must be at least 2 so the byte index has a nonzero width.
module ternary_decompress
  import tnn_pkg::*;
#(
  parameter  int BYTES_PER_WORD = 4,
  localparam int IDX_W          = $clog2(BYTES_PER_WORD),
  localparam int TRIT_W         = 2 * TRITS_PER_BYTE
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic [8*BYTES_PER_WORD-1:0] data_i,
  input  logic [IDX_W-1:0]            nbytes_m1_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [TRIT_W-1:0]           trits_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        last_o,
  output logic                        error_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_t;

  state_t                      state;
  logic [8*BYTES_PER_WORD-1:0] wreg;
  logic [IDX_W-1:0]            idx;
  logic [IDX_W-1:0]            lidx;
  logic [IDX_W-1:0]            next_idx;
  logic [TRIT_W-1:0]           trits_q;
  logic                        error_q;

  logic                        at_last;
  logic                        advance;
  logic                        accept;
  logic [7:0]                  dec_code;
  logic [TRIT_W-1:0]           dec_trits;
  logic                        dec_invalid;

  // The output register is full exactly while a word is in flight.
  assign valid_o  = (state == BUSY);
  assign at_last  = (idx == lidx);
  assign last_o   = valid_o && at_last;
  assign advance  = !valid_o || ready_i;
  // Taking a new word while the last byte drains keeps the stream gapless.
  assign ready_o  = (state == EMPTY) || (at_last && ready_i);
  assign accept   = valid_i && ready_o;
  assign trits_o  = trits_q;
  assign error_o  = error_q;

  // Only one byte is decoded per cycle: byte 0 of an incoming word on
  // accept, otherwise the next byte of the held word. next_idx may wrap
  // on the last byte, but that value is never used.
  assign next_idx = idx + 1'b1;
  assign dec_code = accept ? data_i[7:0] : wreg[{next_idx, 3'b000} +: 8];

  ternary_byte_decode u_decode (
    .code    (dec_code),
    .trits   (dec_trits),
    .invalid (dec_invalid)
  );

  // NOTE: wreg and lidx are pure data qualified by state, so they carry no
  // reset; leaving them out keeps reset fan-out to the control registers.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      wreg <= data_i;
      lidx <= nbytes_m1_i;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= EMPTY;
      idx     <= '0;
      trits_q <= '0;
      error_q <= 1'b0;
    end else if (clear_i) begin
      state   <= EMPTY;
      idx     <= '0;
      trits_q <= '0;
      error_q <= 1'b0;
    end else if (accept) begin
      state   <= BUSY;
      idx     <= '0;
      trits_q <= dec_trits;
      error_q <= error_q | dec_invalid;
    end else if (state == BUSY && advance) begin
      if (!at_last) begin
        idx     <= next_idx;
        trits_q <= dec_trits;
        error_q <= error_q | dec_invalid;
      end else begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_ternary_decompress.sv
// Self-checking bench for ternary_decompress: directed scenarios plus
// randomized words, with a scoreboard fed at accept time and a monitor
// that compares every consumed output byte.
module tb_ternary_decompress;
  import tnn_pkg::*;

  localparam int BPW = 4;

  logic              clk;
  logic              rst_ni;
  logic              clear_i;
  logic [8*BPW-1:0]  data_i;
  logic [1:0]        nbytes_m1_i;
  logic              valid_i;
  logic              ready_o;
  logic [9:0]        trits_o;
  logic              valid_o;
  logic              ready_i;
  logic              last_o;
  logic              error_o;

  ternary_decompress #(.BYTES_PER_WORD(BPW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .data_i      (data_i),
    .nbytes_m1_i (nbytes_m1_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .trits_o     (trits_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .last_o      (last_o),
    .error_o     (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] trits;
    logic       last;
    int         code;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vcount   = 0;
  int   vrises   = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference decode straight from the arithmetic definition.
  function automatic logic [9:0] model_decode(input int code);
    logic [9:0] r;
    int         c;
    int         t;
    r = '0;
    if (code > 242) return r;
    c = code;
    for (int i = 0; i < 5; i++) begin
      t = (c % 3) - 1;
      r[2*i +: 2] = 2'(t);
      c = c / 3;
    end
    return r;
  endfunction

  function automatic int reencode(input logic [9:0] tr);
    int v;
    int p;
    logic signed [1:0] s;
    v = 0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      s = tr[2*i +: 2];
      v = v + (int'(s) + 1) * p;
      p = p * 3;
    end
    return v;
  endfunction

  function automatic bit has_bad_trit(input logic [9:0] tr);
    for (int i = 0; i < 5; i++)
      if (tr[2*i +: 2] == 2'b10) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: compares consumed bytes and checks stability while stalled.
  logic [9:0] prev_trits = '0;
  logic       prev_last  = 1'b0;
  bit         prev_stall = 1'b0;
  bit         prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (prev_stall && valid_o) begin
      check("hold_trits", trits_o, prev_trits);
      check("hold_last", last_o, prev_last);
    end
    if (valid_o) vcount++;
    if (valid_o && !prev_valid) vrises++;
    if (valid_o && ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        check("trits", trits_o, e.trits);
        check("last", last_o, e.last);
        check("no_trit_10", has_bad_trit(trits_o), 0);
        if (e.code <= 242) check("reencode", reencode(trits_o), e.code);
      end
    end
    prev_stall = valid_o && !ready_i;
    prev_trits = trits_o;
    prev_last  = last_o;
    prev_valid = valid_o;
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) ready_i = 1'($urandom_range(0, 1));
  end

  // Drives one word until accepted; returns 1 time unit after the accept edge.
  task automatic send(input logic [31:0] data, input logic [1:0] nm1);
    bit   accepted;
    exp_t e;
    data_i      = data;
    nbytes_m1_i = nm1;
    valid_i     = 1'b1;
    accepted    = 1'b0;
    for (int c = 0; c < 300 && !accepted; c++) begin
      @(negedge clk);
      if (ready_o) begin
        if (valid_o) check("accept_on_last", last_o, 1);
        for (int k = 0; k <= int'(nm1); k++) begin
          e.code  = int'(data[8*k +: 8]);
          e.trits = model_decode(e.code);
          e.last  = (k == int'(nm1));
          sb.push_back(e);
        end
        accepted = 1'b1;
      end
      @(posedge clk);
    end
    if (!accepted) check("accept_timeout", 0, 1);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (!valid_o && sb.size() == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, valid_o, 0);
    check({tag, "_ready"}, ready_o, 1);
    check({tag, "_trits"}, trits_o, 0);
    check({tag, "_last"}, last_o, 0);
    check({tag, "_error"}, error_o, 0);
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  bb;

    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    data_i      = '0;
    nbytes_m1_i = '0;
    valid_i     = 1'b0;
    ready_i     = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;

    // Single word, full throughput.
    vcount = 0; vrises = 0;
    send(32'hF279_0005, 2'd3);
    @(negedge clk);
    check("latency_valid", valid_o, 1);
    drain();
    check("single_cycles", vcount, 4);
    check("single_rises", vrises, 1);

    // Backpressure on output cycles 2-3.
    vcount = 0; vrises = 0;
    send(32'hF279_0005, 2'd3);
    @(posedge clk); #1 ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_trits", trits_o, 10'h3FF);
      check("stall_ready_o", ready_o, 0);
      @(posedge clk);
    end
    #1 ready_i = 1'b1;
    drain();
    check("bp_cycles", vcount, 6);
    check("bp_rises", vrises, 1);

    // Back-to-back words with no bubble.
    vcount = 0; vrises = 0;
    send(32'h0000_0000, 2'd3);
    send(32'h0000_0079, 2'd0);
    drain();
    check("b2b_cycles", vcount, 5);
    check("b2b_rises", vrises, 1);

    // Invalid code: sticky error, cleared by clear_i.
    send(32'h0000_00FF, 2'd0);
    @(negedge clk);
    check("inv_valid", valid_o, 1);
    check("inv_error_rise", error_o, 1);
    drain();
    repeat (10) @(negedge clk);
    check("inv_error_sticky", error_o, 1);
    @(posedge clk); #1 clear_i = 1'b1;
    @(posedge clk); #1 clear_i = 1'b0;
    @(negedge clk);
    check("clear_error", error_o, 0);

    // clear_i together with an invalid word: word dropped, no error.
    @(posedge clk); #1;
    data_i = 32'h0000_00FF; nbytes_m1_i = 2'd0; valid_i = 1'b1; clear_i = 1'b1;
    @(posedge clk); #1 valid_i = 1'b0; clear_i = 1'b0;
    @(negedge clk);
    check("clear_win_valid", valid_o, 0);
    check("clear_win_error", error_o, 0);
    @(posedge clk); #1;

    // Reset after the second byte of a 4-byte word.
    send(32'hF279_0005, 2'd3);
    @(posedge clk); #1 rst_ni = 1'b0;
    @(posedge clk); #1 rst_ni = 1'b1;
    sb.delete();
    @(negedge clk);
    check_idle("midreset");
    @(posedge clk); #1;
    send(32'hF279_0005, 2'd3);
    drain();

    // Exhaustive legal codes, one byte per word, upper bytes random.
    for (int b = 0; b <= MAX_CODE; b++) begin
      r  = $urandom();
      bb = 8'(b);
      send({r[31:8], bb}, 2'd0);
    end
    drain();

    // Random words, random lengths, random consumer stalls.
    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      r = $urandom();
      send(r, 2'($urandom_range(0, 3)));
    end
    drain();
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 ready_i = 1'b1;
    drain();

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
